// File: rtl/vector_alu_pkg.sv
// Shared types for the streaming vector ALU: op table, latched command and FSM states.
package vector_alu_pkg;

  localparam int SCALAR_W = 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_CMP = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_NOT = 3'b111
  } alu_op_e;

  // scalar is held wide so the type stays independent of the element width
  typedef struct packed {
    alu_op_e               op;
    logic [SCALAR_W-1:0]   scalar;
    logic                  scalar_sel;
    logic                  is_signed;
    logic                  sat;
  } alu_cmd_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/vector_lane_op.sv
// Combinational single-lane datapath: wrap/saturate arithmetic, compare and logic ops.
module vector_lane_op
  import vector_alu_pkg::*;
#(
  parameter int BITS       = 8,
  parameter int MULT_SHIFT = 0
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  alu_cmd_t        cmd,
  output logic [BITS-1:0] res,
  output logic            ovf
);

  localparam logic [BITS-1:0] UMAX = '1;
  localparam logic [BITS-1:0] UMIN = '0;
  localparam logic [BITS-1:0] SMAX = {1'b0, {(BITS-1){1'b1}}};
  localparam logic [BITS-1:0] SMIN = {1'b1, {(BITS-1){1'b0}}};
  localparam logic [BITS-1:0] ONE  = {{(BITS-1){1'b0}}, 1'b1};

  logic [BITS:0]          ax, bx, r;
  logic [2*BITS-1:0]      am, bm, prod, sh;
  logic signed [2*BITS-1:0] sh_s;
  logic                   fits_u, fits_s, lt, gt;
  logic                   cmd_unused;

  assign cmd_unused = ^{cmd.scalar, cmd.scalar_sel};

  always_comb begin
    ax   = cmd.is_signed ? {a[BITS-1], a} : {1'b0, a};
    bx   = cmd.is_signed ? {b[BITS-1], b} : {1'b0, b};
    am   = cmd.is_signed ? {{BITS{a[BITS-1]}}, a} : {{BITS{1'b0}}, a};
    bm   = cmd.is_signed ? {{BITS{b[BITS-1]}}, b} : {{BITS{1'b0}}, b};
    // low 2*BITS of the extended product is exact for both signednesses
    prod = am * bm;
    sh_s = $signed(prod) >>> MULT_SHIFT;
    sh   = cmd.is_signed ? sh_s : (prod >> MULT_SHIFT);
    fits_u = ~|sh[2*BITS-1:BITS];
    fits_s = (&sh[2*BITS-1:BITS-1]) | (~|sh[2*BITS-1:BITS-1]);
    lt   = cmd.is_signed ? ($signed(a) < $signed(b)) : (a < b);
    gt   = cmd.is_signed ? ($signed(a) > $signed(b)) : (a > b);
    r    = '0;
    res  = '0;
    ovf  = 1'b0;
    case (cmd.op)
      OP_ADD, OP_SUB: begin
        r   = (cmd.op == OP_ADD) ? (ax + bx) : (ax - bx);
        ovf = cmd.is_signed ? (r[BITS] ^ r[BITS-1]) : r[BITS];
        res = r[BITS-1:0];
        if (ovf && cmd.sat)
          res = cmd.is_signed ? (r[BITS] ? SMIN : SMAX)
                              : ((cmd.op == OP_ADD) ? UMAX : UMIN);
      end
      OP_MUL: begin
        ovf = cmd.is_signed ? ~fits_s : ~fits_u;
        res = sh[BITS-1:0];
        if (ovf && cmd.sat)
          res = cmd.is_signed ? (sh[2*BITS-1] ? SMIN : SMAX) : UMAX;
      end
      OP_CMP:  res = gt ? ONE : (lt ? UMAX : '0);
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/vector_stream_alu.sv
// Streams multi-beat operand packets through a two-stage lane ALU under one latched command.
module vector_stream_alu
  import vector_alu_pkg::*;
#(
  parameter int BITS       = 8,
  parameter int LANES      = 8,
  parameter int MULT_SHIFT = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [2:0]                  cmd_op,
  input  logic [BITS-1:0]             cmd_scalar,
  input  logic                        cmd_scalar_sel,
  input  logic                        cmd_signed,
  input  logic                        cmd_sat,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES-1:0][BITS-1:0]  in_a,
  input  logic [LANES-1:0][BITS-1:0]  in_b,
  input  logic [LANES-1:0]            in_mask,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES-1:0][BITS-1:0]  out_s,
  output logic                        out_last,
  output logic                        out_ovf,
  output logic                        busy
);

  localparam int STAGES = 2;

  fsm_state_e                 state;
  alu_cmd_t                   cmd_q, s1_cmd;
  logic [STAGES:1]            vld_pipe;
  logic [LANES-1:0][BITS-1:0] s1_a, s1_b, lane_res, lane_s;
  logic [LANES-1:0]           s1_mask, lane_ovf;
  logic                       s1_last, sticky, beat_ovf;
  logic                       stall, in_fire, cmd_fire, s1_en;
  logic                       scalar_unused;

  assign scalar_unused = ^cmd_q.scalar;

  assign out_valid = vld_pipe[2];
  assign stall     = vld_pipe[2] & ~out_ready;
  assign in_ready  = (state == ST_ACTIVE) & ~(vld_pipe[1] & stall);
  assign in_fire   = in_valid & in_ready;
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign busy      = (state != ST_IDLE) | (|vld_pipe);
  // S1 may refill into a bubble even while the output is stalled
  assign s1_en     = ~vld_pipe[1] | ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd_q     <= '0;
      cmd_ready <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_fire) begin
            cmd_q     <= '{op: alu_op_e'(cmd_op), scalar: SCALAR_W'(cmd_scalar),
                           scalar_sel: cmd_scalar_sel, is_signed: cmd_signed, sat: cmd_sat};
            state     <= ST_ACTIVE;
            cmd_ready <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (in_fire && in_last) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vector_lane_op #(.BITS(BITS), .MULT_SHIFT(MULT_SHIFT)) u_lane (
      .a   (s1_a[g]),
      .b   (s1_b[g]),
      .cmd (s1_cmd),
      .res (lane_res[g]),
      .ovf (lane_ovf[g])
    );
    assign lane_s[g] = s1_mask[g] ? lane_res[g] : s1_a[g];
  end

  assign beat_ovf = |(lane_ovf & s1_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mask  <= '0;
      s1_last  <= 1'b0;
      s1_cmd   <= '0;
      out_s    <= '0;
      out_last <= 1'b0;
      out_ovf  <= 1'b0;
      sticky   <= 1'b0;
    end else begin
      if (s1_en) begin
        vld_pipe[1] <= in_fire;
        if (in_fire) begin
          // each beat carries its command so a new one can be latched while this drains
          s1_a    <= in_a;
          s1_b    <= cmd_q.scalar_sel ? {LANES{cmd_q.scalar[BITS-1:0]}} : in_b;
          s1_mask <= in_mask;
          s1_last <= in_last;
          s1_cmd  <= cmd_q;
        end
      end
      if (!stall) begin
        vld_pipe[2] <= vld_pipe[1];
        out_last    <= vld_pipe[1] & s1_last;
        out_ovf     <= vld_pipe[1] & s1_last & (sticky | beat_ovf);
        if (vld_pipe[1]) begin
          out_s  <= lane_s;
          sticky <= s1_last ? 1'b0 : (sticky | beat_ovf);
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_stream_alu.sv
// Directed vector table plus hand-written packet, backpressure and reset sequences.
module tb_vector_stream_alu;

  localparam int BITS = 8, LANES = 4, MSH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, cmd_valid, cmd_ready, cmd_scalar_sel, cmd_signed, cmd_sat;
  logic [2:0] cmd_op;
  logic [BITS-1:0] cmd_scalar;
  logic in_valid, in_ready, in_last, out_valid, out_ready, out_last, out_ovf, busy;
  logic [LANES-1:0][BITS-1:0] in_a, in_b, out_s;
  logic [LANES-1:0] in_mask;

  vector_stream_alu #(.BITS(BITS), .LANES(LANES), .MULT_SHIFT(MSH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_scalar(cmd_scalar), .cmd_scalar_sel(cmd_scalar_sel),
    .cmd_signed(cmd_signed), .cmd_sat(cmd_sat), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mask(in_mask), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .out_last(out_last),
    .out_ovf(out_ovf), .busy(busy)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic        sc_sel;
    logic [7:0]  scalar;
    logic        sgn, sat;
    logic [31:0] a, b;
    logic [3:0]  mask;
    logic [31:0] exp_s;
    logic        exp_ovf;
  } vec_t;

  typedef struct packed { logic [31:0] s; logic last; logic ovf; } res_t;

  int tests = 0, fails = 0, acc_cnt = 0;
  res_t q[$];
  vec_t vecs[$];

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) q.push_back('{s: out_s, last: out_last, ovf: out_ovf});

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [2:0] op, input logic sc_sel,
                              input logic [7:0] sc, input logic sgn, input logic sat,
                              input logic [31:0] a, input logic [31:0] b, input logic [3:0] mask,
                              input logic [31:0] e, input logic eo);
    vec_t v;
    v.name = n; v.op = op; v.sc_sel = sc_sel; v.scalar = sc; v.sgn = sgn; v.sat = sat;
    v.a = a; v.b = b; v.mask = mask; v.exp_s = e; v.exp_ovf = eo;
    return v;
  endfunction

  // All tasks are entered just after a rising edge and return just after one.
  task automatic send_cmd(input logic [2:0] op, input logic sc_sel, input logic [7:0] sc,
                          input logic sgn, input logic sat);
    int t = 0;
    bit ok = 0;
    cmd_op = op; cmd_scalar_sel = sc_sel; cmd_scalar = sc; cmd_signed = sgn; cmd_sat = sat;
    cmd_valid = 1'b1;
    while (!ok && t < 100) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
      @(posedge clk); #1;
      t++;
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL cmd_handshake: got timeout expected cmd_ready");
    end
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic [3:0] mask,
                           input logic last);
    int t = 0;
    bit ok = 0;
    in_a = a; in_b = b; in_mask = mask; in_last = last; in_valid = 1'b1;
    while (!ok && t < 100) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; acc_cnt++; end
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL beat_handshake: got timeout expected in_ready");
    end
  endtask

  task automatic wait_out(input int n);
    int t = 0;
    while (q.size() < n && t < 200) begin @(negedge clk); t++; end
    if (q.size() < n) begin
      tests++; fails++;
      $display("FAIL out_timeout: got %0d results expected %0d", q.size(), n);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v);
    res_t r;
    send_cmd(v.op, v.sc_sel, v.scalar, v.sgn, v.sat);
    send_beat(v.a, v.b, v.mask, 1'b1);
    wait_out(1);
    if (q.size() > 0) begin
      r = q.pop_front();
      check({v.name, "_s"}, r.s, v.exp_s);
      check({v.name, "_ovf"}, {31'd0, r.ovf}, {31'd0, v.exp_ovf});
    end
  endtask

  initial begin
    logic [31:0] pk_a[4], pk_e[4], hold;
    logic [3:0]  pk_o, pk_l;
    bit stable;
    int t;
    res_t r;

    vecs.push_back(mk("add_u_wrap", 3'd0, 0, 8'd0, 0, 0, 32'hC8C8C8C8, 32'h64646464, 4'hF, 32'h2C2C2C2C, 1));
    vecs.push_back(mk("add_u_sat",  3'd0, 0, 8'd0, 0, 1, 32'hC8C8C8C8, 32'h64646464, 4'hF, 32'hFFFFFFFF, 1));
    vecs.push_back(mk("sub_s_sat",  3'd1, 0, 8'd0, 1, 1, 32'h9C9C9C9C, 32'h64646464, 4'hF, 32'h80808080, 1));
    vecs.push_back(mk("sub_s_ok",   3'd1, 0, 8'd0, 1, 1, 32'h05050505, 32'h03030303, 4'hF, 32'h02020202, 0));
    vecs.push_back(mk("mul_u",      3'd2, 0, 8'd0, 0, 0, 32'h20202020, 32'h30303030, 4'hF, 32'h60606060, 0));
    vecs.push_back(mk("mul_u_sat",  3'd2, 0, 8'd0, 0, 1, 32'hF0F0F0F0, 32'hF0F0F0F0, 4'hF, 32'hFFFFFFFF, 1));
    vecs.push_back(mk("mul_u_wrap", 3'd2, 0, 8'd0, 0, 0, 32'hF0F0F0F0, 32'hF0F0F0F0, 4'hF, 32'h10101010, 1));
    vecs.push_back(mk("mul_s",      3'd2, 0, 8'd0, 1, 1, 32'hF0F0F0F0, 32'h20202020, 4'hF, 32'hE0E0E0E0, 0));
    vecs.push_back(mk("cmp_s",      3'd3, 0, 8'd0, 1, 1, 32'h0701FFFF, 32'h07FF0101, 4'hF, 32'h0001FFFF, 0));
    vecs.push_back(mk("cmp_u",      3'd3, 0, 8'd0, 0, 0, 32'h0701FFFF, 32'h07FF0101, 4'hF, 32'h00FF0101, 0));
    vecs.push_back(mk("scalar_msk", 3'd0, 1, 8'd3, 0, 0, 32'h281E140A, 32'hFFFFFFFF, 4'b0101, 32'h2821140D, 0));
    vecs.push_back(mk("and",        3'd4, 0, 8'd0, 1, 1, 32'hF0F0F0F0, 32'h3C3C3C3C, 4'hF, 32'h30303030, 0));
    vecs.push_back(mk("or",         3'd5, 0, 8'd0, 1, 1, 32'hF0F0F0F0, 32'h3C3C3C3C, 4'hF, 32'hFCFCFCFC, 0));
    vecs.push_back(mk("xor",        3'd6, 0, 8'd0, 1, 1, 32'hF0F0F0F0, 32'h3C3C3C3C, 4'hF, 32'hCCCCCCCC, 0));
    vecs.push_back(mk("not",        3'd7, 0, 8'd0, 1, 1, 32'hF0F0F0F0, 32'h3C3C3C3C, 4'hF, 32'h0F0F0F0F, 0));
    vecs.push_back(mk("mask_none",  3'd0, 0, 8'd0, 0, 0, 32'hC8C8C8C8, 32'h64646464, 4'h0, 32'hC8C8C8C8, 0));
    vecs.push_back(mk("add_s_wrap", 3'd0, 0, 8'd0, 1, 0, 32'h7F7F7F7F, 32'h01010101, 4'hF, 32'h80808080, 1));
    vecs.push_back(mk("add_s_sat",  3'd0, 0, 8'd0, 1, 1, 32'h7F7F7F7F, 32'h01010101, 4'hF, 32'h7F7F7F7F, 1));
    vecs.push_back(mk("sub_u_sat",  3'd1, 0, 8'd0, 0, 1, 32'h03030303, 32'h05050505, 4'hF, 32'h00000000, 1));
    vecs.push_back(mk("mask_ovf",   3'd0, 0, 8'd0, 0, 0, 32'hC8010101, 32'h64010101, 4'b0111, 32'hC8020202, 0));

    rst_n = 1'b0; cmd_valid = 0; cmd_op = 0; cmd_scalar = 0; cmd_scalar_sel = 0;
    cmd_signed = 0; cmd_sat = 0; in_valid = 0; in_a = '0; in_b = '0; in_mask = '0;
    in_last = 0; out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready}, 32'd0);
    check("rst_flags", {28'd0, out_valid, out_last, out_ovf, busy}, 32'd0);
    check("rst_out_s", out_s, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // 4-beat scalar packet: only the third beat overflows, flag must surface on the last beat
    pk_a = '{32'h01020304, 32'h10101010, 32'hF8000000, 32'h00000000};
    pk_e = '{32'h11121314, 32'h20202020, 32'h08101010, 32'h10101010};
    send_cmd(3'd0, 1'b1, 8'h10, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_beat(pk_a[i], 32'h0, 4'hF, (i == 3));
    wait_out(4);
    for (int i = 0; i < 4; i++) begin
      if (q.size() > 0) begin
        r = q.pop_front();
        check($sformatf("pkt_s%0d", i), r.s, pk_e[i]);
        check($sformatf("pkt_ovf%0d", i), {31'd0, r.ovf}, {31'd0, (i == 3)});
        check($sformatf("pkt_last%0d", i), {31'd0, r.last}, {31'd0, (i == 3)});
      end
    end

    // backpressure: 6 beats with the output held off at the start
    out_ready = 1'b0;
    acc_cnt = 0;
    send_cmd(3'd0, 1'b0, 8'h0, 1'b0, 1'b0);
    fork
      begin
        for (int i = 0; i < 6; i++) send_beat({4{8'(i + 1)}}, 32'h10101010, 4'hF, (i == 5));
      end
      begin
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 50) begin @(negedge clk); t++; end
        check("bp_inflight", acc_cnt, 32'd2);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        hold = out_s;
        stable = 1;
        repeat (4) begin
          @(negedge clk);
          if (out_s !== hold || !out_valid || in_ready) stable = 0;
        end
        check("bp_stable", {31'd0, stable}, 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_out(6);
    for (int i = 0; i < 6; i++) begin
      if (q.size() > 0) begin
        r = q.pop_front();
        check($sformatf("bp_s%0d", i), r.s, {4{8'(i + 17)}});
        check($sformatf("bp_last%0d", i), {31'd0, r.last}, {31'd0, (i == 5)});
      end
    end
    check("bp_no_extra", q.size(), 32'd0);

    // reset mid-packet
    send_cmd(3'd0, 1'b0, 8'h0, 1'b0, 1'b0);
    send_beat(32'h01010101, 32'h01010101, 4'hF, 1'b0);
    send_beat(32'h02020202, 32'h01010101, 4'hF, 1'b0);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_flags", {29'd0, out_valid, busy, in_ready}, 32'd0);
    q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_idle", {30'd0, cmd_ready, busy}, 32'd2);
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
